// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - UART TX scheduler: CPU registers, TX FIFO, start/done handshake to the TX core.
// Optional TX-drained interrupt is enabled by defining UART_TXIRQ_EN.
module uart_tx_sched #(
  parameter int          DEPTH    = 4,
  parameter logic [10:0] DVSR_RST = 11'd27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_enable,
  input  logic [4:0]  address,
  input  logic [31:0] data_in,
  input  logic        tx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic [10:0] dvsr,
  output logic        busy,
  output logic [31:0] cout,
  output logic        irq
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;
  state_t state, state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [4:0]    cnt5;
  logic [10:0]   shadow;
  logic [1:0]    idx;
  logic          full, empty, push, pop;
  logic          ovf, en, ie;
  logic          wr_data, wr_div, wr_ctrl;
  logic          unused_bits;

  assign idx     = address[3:2];
  assign wr_data = write_enable && (idx == 2'd0);
  assign wr_div  = write_enable && (idx == 2'd1);
  assign wr_ctrl = write_enable && (idx == 2'd2);
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push    = wr_data && !full;
  assign pop     = (state == LOAD);
  assign busy    = (state != IDLE);
  assign cnt5    = 5'(count);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in[7:0];
  end

  // dvsr only follows the shadow while IDLE so a frame in flight keeps its rate
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf    <= 1'b0;
      en     <= 1'b0;
      shadow <= DVSR_RST;
      dvsr   <= DVSR_RST;
    end else begin
      if (wr_data && full)            ovf <= 1'b1;
      else if (wr_ctrl && data_in[2]) ovf <= 1'b0;
      if (wr_div)  shadow <= data_in[10:0];
      if (wr_ctrl) en     <= data_in[0];
      if (state == IDLE) dvsr <= shadow;
    end
  end

`ifdef UART_TXIRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr_ctrl) ie <= data_in[1];
      if (wr_data || !ie)                        irq <= 1'b0;
      else if (state == WAIT && tx_done && empty) irq <= 1'b1;
    end
  end
`else
  assign ie  = 1'b0;
  assign irq = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en && !empty) state_nxt = LOAD;
      LOAD:    state_nxt = WAIT;
      WAIT:    if (tx_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data  <= 8'd0;
      tx_start <= 1'b0;
    end else begin
      tx_start <= (state == LOAD);
      if (state == LOAD) tx_data <= mem[rd_ptr];
    end
  end

  always_comb begin
    cout = 32'd0;
    case (idx)
      2'd1:    cout = {21'd0, shadow};
      2'd2:    cout = {29'd0, 1'b0, ie, en};
      2'd3:    cout = {24'd0, cnt5[3:0], ovf, busy, empty, full};
      default: cout = 32'd0;
    endcase
  end

  assign unused_bits = ^{address[4], address[1:0], data_in[31:11], data_in[1], cnt5[4]};

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning TX FIFO entries (power of 2, 2..16).
REQ-002 The block SHALL have parameter DVSR_RST, default 11'd27, meaning divisor value after reset.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port write_enable  input  1  CPU register write strobe.
REQ-006 The block SHALL have port address  input  5  CPU byte address; word index = address[3:2].
REQ-007 The block SHALL have port data_in  input  32  CPU write data.
REQ-008 The block SHALL have port tx_done  input  1  one-cycle pulse from the TX core at end of a frame.
REQ-009 The block SHALL have port tx_data  output  8  byte presented to the TX core.
REQ-010 The block SHALL have port tx_start  output  1  one-cycle start pulse to the TX core.
REQ-011 The block SHALL have port dvsr  output  11  active baud divisor.
REQ-012 The block SHALL have port busy  output  1  high while the FSM is not in IDLE.
REQ-013 The block SHALL have port cout  output  32  combinational read data for address.
REQ-014 The block SHALL have port irq  output  1  TX-drained interrupt (see Configuration).

Function
REQ-015 The register map SHALL be: idx 0 DATA (write-only push), idx 1 DIV, idx 2 CTRL, idx 3 STATUS (read-only); DATA reads as 0.
REQ-016 A DATA write SHALL push data_in[7:0] when the FIFO is not full at that cycle; a write while full is dropped and sets sticky OVF, even when a pop occurs in the same cycle.
REQ-017 A DIV write SHALL load a shadow register; dvsr SHALL take the shadow value only on a cycle where the FSM is in IDLE, so a frame never changes rate mid-byte.
REQ-018 CTRL SHALL hold bit0 EN, bit1 IE; writing 1 to bit2 SHALL clear OVF (bit2 reads 0).
REQ-019 STATUS SHALL read {24'b0, count[3:0], OVF, busy, empty, full} in bits [7:0], count zero-extended.
REQ-020 The FSM SHALL have states IDLE, LOAD, WAIT.
REQ-021 IDLE->LOAD SHALL occur when EN=1 and the FIFO is non-empty.
REQ-022 In LOAD, tx_data SHALL register the FIFO head, the head SHALL be popped, and the FSM SHALL go to WAIT.
REQ-023 tx_start SHALL be high exactly the first cycle in WAIT; tx_data SHALL stay stable throughout WAIT.
REQ-024 WAIT->IDLE SHALL occur on tx_done; tx_done in IDLE or LOAD SHALL be ignored.
REQ-025 Latency: a push into an empty FIFO with EN=1 at posedge N SHALL produce tx_start high in the cycle after posedge N+2.
REQ-026 Back-to-back frames SHALL have 2 idle cycles (IDLE, LOAD) between tx_done and the next tx_start.
REQ-027 Clearing EN during WAIT SHALL let the current frame finish; no new LOAD SHALL occur until EN=1.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH, with full=(count==DEPTH) and empty=(count==0).
REQ-029 A simultaneous push and pop on a non-full FIFO SHALL leave count unchanged.

Reset
REQ-030 While rst=1 at posedge clk: FSM=IDLE, FIFO empty, OVF=0, EN=0, IE=0, shadow and dvsr=DVSR_RST, tx_data=0, tx_start=0, busy=0, irq=0.
REQ-031 Reset mid-WAIT SHALL abandon the frame; a later tx_done SHALL be ignored.

Configuration
REQ-032 With UART_TXIRQ_EN defined, irq SHALL be a register set when IE=1, the FSM enters IDLE from WAIT, and the FIFO is empty; it SHALL clear on any DATA write or on IE=0.
REQ-033 Without UART_TXIRQ_EN, irq SHALL be constant 0, IE SHALL read 0, and no irq flop SHALL exist.

Verification
REQ-034 Reset, then write CTRL=1 and DATA=0x41 -> tx_start pulses once after 2 cycles, tx_data=0x41, busy=1 until tx_done, STATUS empty=1 afterwards.
REQ-035 With EN=0, push 5 bytes at DEPTH=4 -> STATUS full=1, count=4, OVF=1; writing CTRL=0x4 clears OVF.
REQ-036 Push 0x10,0x20,0x30, then EN=1, and return tx_done 10 cycles after each start -> three starts in order, 2-cycle gaps.
REQ-037 Write DIV=100 during WAIT -> dvsr stays 27 until tx_done, then becomes 100 the cycle after the FSM reaches IDLE.
REQ-038 Assert rst mid-WAIT, then pulse tx_done -> no tx_start, busy=0, FIFO empty. With UART_TXIRQ_EN and IE=1, draining the last byte -> irq=1; a DATA write -> irq=0.
